// File: rtl/timer_dev_if.sv
// Processor-bus slave port of the countdown timer: address, write strobe,
// byte enables and data toward the device; read data and window hit back.
interface timer_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Hit;

  modport master (output Addr, WE, BE, WD, input RD, Hit);
  modport slave  (input Addr, WE, BE, WD, output RD, Hit);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT in a 16-byte window,
// one-shot (held interrupt) or auto-reload (one-cycle pulse) operation.
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic       clk,
  input  logic       reset,
  timer_dev_if.slave bus,
  output logic       IRQ
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_ctrl;
  logic [DW-1:0] r_preset;
  logic [DW-1:0] r_count;
  logic          r_pending;
  logic          r_pulse;

  logic          w_wr_ctrl;
  logic          w_wr_preset;
  logic          w_mode1;
  logic [DW-1:0] w_be_mask;
  logic [DW-1:0] w_preset_nxt;
  logic [CW-1:0] w_ctrl_nxt;
  logic          w_unused_addr;

  assign bus.Hit       = (bus.Addr[31:4] == BASE[31:4]);
  assign w_wr_ctrl     = bus.Hit & bus.WE & (bus.Addr[3:2] == 2'd0);
  assign w_wr_preset   = bus.Hit & bus.WE & (bus.Addr[3:2] == 2'd1);
  assign w_mode1       = (r_ctrl[2:1] == 2'b01);
  assign w_be_mask     = {{8{bus.BE[3]}}, {8{bus.BE[2]}}, {8{bus.BE[1]}}, {8{bus.BE[0]}}};
  assign w_preset_nxt  = (r_preset & ~w_be_mask) | (bus.WD & w_be_mask);
  assign w_unused_addr = ^bus.Addr[1:0];

  // One-shot expiry clears EN, but a same-edge bus write to CTRL takes precedence
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (r_state == S_INT && !w_mode1) begin
      w_ctrl_nxt[0] = 1'b0;
    end
    if (w_wr_ctrl && bus.BE[0]) begin
      w_ctrl_nxt = bus.WD[CW-1:0];
    end
  end

  always_comb begin
    bus.RD = '0;
    if (bus.Hit) begin
      case (bus.Addr[3:2])
        2'd0:    bus.RD = {(DW-CW)'(0), r_ctrl};
        2'd1:    bus.RD = r_preset;
        2'd2:    bus.RD = r_count;
        default: bus.RD = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_pulse <= 1'b0;
      if (w_wr_preset) begin
        r_preset <= w_preset_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (r_ctrl[0]) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (r_count > DW'(1)) begin
            r_count <= r_count - DW'(1);
          end else begin
            r_count <= '0;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          if (w_mode1) begin
            r_pulse <= 1'b1;
          end else begin
            r_pending <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Any CTRL access acknowledges, overriding a same-edge expiry
      if (w_wr_ctrl) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign IRQ = r_ctrl[3] & (r_pending | r_pulse);

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected read/IRQ/Hit values,
// a monitor process samples the DUT and compares on each sample request.
module tb_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RES  = 32'h0000_7F0C;
  localparam logic [31:0] A_OUT  = 32'h0000_7F10;
  localparam int unsigned K_RD  = 0;
  localparam int unsigned K_IRQ = 1;
  localparam int unsigned K_HIT = 2;

  typedef struct {
    string       name;
    int unsigned kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event ev_sample;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic irq;

  timer_dev_if bus();

  timer_dev #(.BASE(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (irq)
  );

  always #10 clk = ~clk;

  // Monitor: pop the oldest expectation and compare against the live DUT output
  initial begin
    forever begin
      exp_t        e;
      logic [31:0] act;
      @(ev_sample);
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL monitor: sample requested with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_IRQ:   act = {31'd0, irq};
          K_HIT:   act = {31'd0, bus.Hit};
          default: act = bus.RD;
        endcase
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus.Addr = addr;
    bus.BE   = be;
    bus.WD   = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic chk(input string name, input int unsigned kind,
                     input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    bus.Addr = addr;
    bus.WE   = 1'b0;
    e.name   = name;
    e.kind   = kind;
    e.exp    = exp;
    sb_q.push_back(e);
    #1;
    -> ev_sample;
    #1;
  endtask

  initial begin
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.BE   = '0;
    bus.WD   = '0;

    // Reset state
    step(2);
    chk("rst_ctrl", K_RD, A_CTRL, 32'h0);
    chk("rst_count", K_RD, A_CNT, 32'h0);
    chk("rst_irq", K_IRQ, A_CTRL, 32'h0);
    reset = 1'b1;
    step(1);

    // One-shot, PRESET=5: COUNT 5..1 from E+2, 0 at E+7, IRQ held from E+8
    wr(A_PRE, 4'hF, 32'd5);
    wr(A_CTRL, 4'hF, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("m0_count_e%0d", k), K_RD, A_CNT, (k == 1) ? 32'd0 : 32'(7 - k));
      chk($sformatf("m0_irq_e%0d", k), K_IRQ, A_CTRL, 32'd0);
    end
    step(1);
    chk("m0_irq_e8", K_IRQ, A_CTRL, 32'd1);
    chk("m0_ctrl_after", K_RD, A_CTRL, 32'h8);
    step(1);
    chk("m0_irq_held", K_IRQ, A_CTRL, 32'd1);

    // Acknowledge by CTRL write, then a masked one-shot run
    wr(A_CTRL, 4'hF, 32'h8);
    chk("ack_irq", K_IRQ, A_CTRL, 32'd0);
    wr(A_PRE, 4'hF, 32'd2);
    wr(A_CTRL, 4'hF, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("masked_irq_e%0d", k), K_IRQ, A_CTRL, 32'd0);
    end
    chk("masked_ctrl", K_RD, A_CTRL, 32'h0);
    chk("masked_count", K_RD, A_CNT, 32'h0);

    // Auto-reload, PRESET=3: single-cycle pulses at E+6, E+12, E+18
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CTRL, 4'hF, 32'hB);
    for (int k = 1; k <= 19; k++) begin
      step(1);
      chk($sformatf("m1_irq_e%0d", k), K_IRQ, A_CTRL, (k % 6 == 0) ? 32'd1 : 32'd0);
      if (k == 2 || k == 8) chk($sformatf("m1_count_e%0d", k), K_RD, A_CNT, 32'd3);
      if (k == 5) chk("m1_count_e5", K_RD, A_CNT, 32'd0);
    end
    wr(A_CTRL, 4'hF, 32'h0);
    step(2);
    chk("m1_stop_irq", K_IRQ, A_CTRL, 32'd0);
    chk("m1_stop_count", K_RD, A_CNT, 32'd3);

    // Byte enables, read-only COUNT, reserved slot
    wr(A_PRE, 4'hF, 32'h0);
    wr(A_PRE, 4'b0001, 32'hFFFF_FFFF);
    chk("be0_preset", K_RD, A_PRE, 32'h0000_00FF);
    wr(A_PRE, 4'b0100, 32'h00AB_0000);
    chk("be2_preset", K_RD, A_PRE, 32'h00AB_00FF);
    wr(A_CNT, 4'hF, 32'h1234_5678);
    chk("count_ro", K_RD, A_CNT, 32'd3);
    wr(A_RES, 4'hF, 32'hFFFF_FFFF);
    chk("reserved_rd", K_RD, A_RES, 32'h0);
    wr(A_CTRL, 4'b1110, 32'h0000_000F);
    chk("ctrl_be_off", K_RD, A_CTRL, 32'h0);

    // Out-of-window access
    wr(A_OUT, 4'hF, 32'hDEAD_BEEF);
    chk("out_hit", K_HIT, A_OUT, 32'd0);
    chk("out_rd", K_RD, A_OUT, 32'h0);
    chk("out_preset_kept", K_RD, A_PRE, 32'h00AB_00FF);
    chk("in_hit", K_HIT, A_CTRL, 32'd1);

    // EN cleared mid-count freezes COUNT; re-enable restarts from LOAD
    wr(A_PRE, 4'hF, 32'd10);
    wr(A_CTRL, 4'hF, 32'h1);
    step(4);
    chk("frz_count_e4", K_RD, A_CNT, 32'd8);
    wr(A_CTRL, 4'hF, 32'h0);
    chk("frz_count_e5", K_RD, A_CNT, 32'd7);
    step(3);
    chk("frz_count_held", K_RD, A_CNT, 32'd7);
    chk("frz_irq", K_IRQ, A_CTRL, 32'd0);
    wr(A_CTRL, 4'hF, 32'h9);
    step(2);
    chk("restart_count", K_RD, A_CNT, 32'd10);
    step(1);
    chk("restart_dec", K_RD, A_CNT, 32'd9);

    // Asynchronous reset mid-count
    reset = 1'b0;
    #1;
    chk("arst_ctrl", K_RD, A_CTRL, 32'h0);
    chk("arst_preset", K_RD, A_PRE, 32'h0);
    chk("arst_count", K_RD, A_CNT, 32'h0);
    chk("arst_irq", K_IRQ, A_CTRL, 32'd0);
    reset = 1'b1;
    step(1);

    // PRESET=1 one-shot: IRQ at E+4, then async reset drops it without a clock edge
    wr(A_PRE, 4'hF, 32'd1);
    wr(A_CTRL, 4'hF, 32'h9);
    step(3);
    chk("p1_irq_e3", K_IRQ, A_CTRL, 32'd0);
    step(1);
    chk("p1_irq_e4", K_IRQ, A_CTRL, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_irq_held", K_IRQ, A_CTRL, 32'd0);
    chk("arst_ctrl2", K_RD, A_CTRL, 32'h0);
    reset = 1'b1;
    step(1);

    #2;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
